// File: rtl/gpio_debounce_pkg.sv
// Shared constants and helpers for the GPIO input debouncer.
package gpio_debounce_pkg;

  localparam int unsigned DebounceMs = 10;

  // Counter width for a given threshold; a threshold of 1 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic int unsigned debounce_cycles(input int unsigned clk_hz);
    return clk_hz / 1000 * DebounceMs;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and registered edge pulses.
module debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = 4,
  parameter logic        ResetValue     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int unsigned        CntW   = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0]    CntMax = CntW'(DebounceCycles - 1);

  (* ASYNC_REG = "TRUE" *) logic s1;
  logic            s2;
  logic [CntW-1:0] cnt;

  // Registered-state only, so the top can register an OR of these alongside rise/fall.
  assign accept = (s2 != level) && (cnt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= ResetValue;
      s2    <= ResetValue;
      cnt   <= '0;
      level <= ResetValue;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      rise <= accept & s2;
      fall <= accept & ~s2;
      if ((s2 == level) || accept) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (accept) level <= s2;
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// Synchronises and debounces Width independent inputs into levels plus rise/fall events.
module gpio_debounce #(
  parameter int unsigned       Width          = 16,
  parameter int unsigned       DebounceCycles = 400_000,
  parameter logic [Width-1:0]  ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] pins_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  logic [Width-1:0] accept;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    debounce_bit #(
      .DebounceCycles (DebounceCycles),
      .ResetValue     (ResetValue[i])
    ) u_bit (
      .clk    (clk_sys_i),
      .rst    (rst_sys_i),
      .pin    (pins_i[i]),
      .level  (level_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i]),
      .accept (accept[i])
    );
  end

  // Every accept produces exactly one rise or fall, so this lines up with them.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) changed_o <= 1'b0;
    else           changed_o <= |accept;
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Randomised and directed bench for gpio_debounce against a sliding-window reference model.
module tb_gpio_debounce;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pins0, pins1;
  logic [W-1:0] level0, rise0, fall0, level1, rise1, fall1;
  logic         chg0, chg1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_debounce #(.Width(W), .DebounceCycles(4), .ResetValue(16'h0000)) u_dut0 (
    .clk_sys_i(clk), .rst_sys_i(rst), .pins_i(pins0),
    .level_o(level0), .rise_o(rise0), .fall_o(fall0), .changed_o(chg0));

  gpio_debounce #(.Width(W), .DebounceCycles(1), .ResetValue(16'h8000)) u_dut1 (
    .clk_sys_i(clk), .rst_sys_i(rst), .pins_i(pins1),
    .level_o(level1), .rise_o(rise1), .fall_o(fall1), .changed_o(chg1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a new level is accepted once the last D synchronised samples all differ from it.
  logic [W-1:0] m_s1[2], m_s2[2], m_lvl[2], m_rise[2], m_fall[2];
  logic         m_chg[2];
  logic [W-1:0] m_hist[2][4];
  int           m_n[2];

  task automatic model(input int k, input int dd, input logic [W-1:0] rv, input logic [W-1:0] p);
    logic [W-1:0] s2old, acc;
    if (rst) begin
      m_s1[k] = rv; m_s2[k] = rv; m_lvl[k] = rv;
      m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0; m_n[k] = 0;
    end else begin
      s2old = m_s2[k];
      for (int j = dd - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = s2old;
      if (m_n[k] < dd) m_n[k]++;
      acc = (m_n[k] == dd) ? '1 : '0;
      for (int j = 0; j < dd; j++) acc &= m_hist[k][j] ^ m_lvl[k];
      m_rise[k] = acc & s2old;
      m_fall[k] = acc & ~s2old;
      m_chg[k]  = |acc;
      m_lvl[k]  = m_lvl[k] ^ acc;
      m_s2[k]   = m_s1[k];
      m_s1[k]   = p;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(0, 4, 16'h0000, pins0);
    model(1, 1, 16'h8000, pins1);
    @(negedge clk);
    check("level0", level0, m_lvl[0]);
    check("rise0",  rise0,  m_rise[0]);
    check("fall0",  fall0,  m_fall[0]);
    check("chg0",   chg0,   m_chg[0]);
    check("level1", level1, m_lvl[1]);
    check("rise1",  rise1,  m_rise[1]);
    check("fall1",  fall1,  m_fall[1]);
    check("chg1",   chg1,   m_chg[1]);
  endtask

  // Event recorder: first step (1-based) of each pulse and pulse-cycle counts.
  int w_fr[W], w_ff[W], w_nr[W], w_nf[W];
  int w_nc;

  task automatic watch(input int k, input int nmax);
    logic [W-1:0] r, f;
    logic c;
    for (int b = 0; b < W; b++) begin w_fr[b] = -1; w_ff[b] = -1; w_nr[b] = 0; w_nf[b] = 0; end
    w_nc = 0;
    for (int s = 1; s <= nmax; s++) begin
      step();
      r = (k == 0) ? rise0 : rise1;
      f = (k == 0) ? fall0 : fall1;
      c = (k == 0) ? chg0  : chg1;
      if (c) w_nc++;
      for (int b = 0; b < W; b++) begin
        if (r[b]) begin w_nr[b]++; if (w_fr[b] < 0) w_fr[b] = s; end
        if (f[b]) begin w_nf[b]++; if (w_ff[b] < 0) w_ff[b] = s; end
      end
    end
  endtask

  initial begin
    rst = 1'b1; pins0 = '1; pins1 = 16'h8000;
    repeat (3) step();
    check("rst_level", level0, 16'h0000);
    check("rst_rise",  rise0,  16'h0000);
    check("rst_chg",   chg0,   0);
    rst = 1'b0;
    watch(0, 8);
    check("rel_rise_at0",  w_fr[0], 6);
    check("rel_rise_at15", w_fr[15], 6);
    check("rel_nrise9",    w_nr[9], 1);
    check("rel_nchg",      w_nc, 1);
    check("rel_level",     level0, 16'hFFFF);
    pins0 = '0;
    watch(0, 8);
    check("all_fall_at4", w_ff[4], 6);

    // Glitch of 3 cycles is dropped; 4 cycles is accepted.
    pins0 = 16'h0008;
    repeat (3) step();
    pins0 = '0;
    watch(0, 10);
    check("glitch_nrise", w_nr[3], 0);
    check("glitch_level", level0[3], 0);
    pins0 = 16'h0008;
    repeat (4) step();
    pins0 = '0;
    watch(0, 12);
    check("p4_rise_at", w_fr[3], 2);
    check("p4_fall_at", w_ff[3], 6);
    check("p4_nrise",   w_nr[3], 1);

    // Bounce then settle high.
    for (int i = 0; i < 20; i++) begin
      pins0[0] = ((i / 2) % 2 == 0);
      step();
    end
    check("bounce_level", level0[0], 0);
    pins0[0] = 1'b1;
    watch(0, 10);
    check("bounce_rise_at", w_fr[0], 6);
    check("bounce_nrise",   w_nr[0], 1);
    check("bounce_nfall",   w_nf[0], 0);
    pins0 = '0;
    watch(0, 10);

    // Independent bits, two cycles apart.
    pins0 = 16'h0002;
    repeat (2) step();
    pins0 = 16'h0006;
    watch(0, 8);
    check("ind_rise1_at", w_fr[1], 4);
    check("ind_rise2_at", w_fr[2], 6);
    check("ind_nrise1",   w_nr[1], 1);
    check("ind_nrise2",   w_nr[2], 1);
    check("ind_nchg",     w_nc, 2);
    pins0 = '0;
    watch(0, 10);

    // Reset in the middle of a count.
    pins0 = 16'h0020;
    repeat (4) step();
    rst = 1'b1;
    watch(0, 3);
    check("mid_nrise",  w_nr[5], 0);
    check("mid_level",  level0[5], 0);
    rst = 1'b0;
    watch(0, 8);
    check("mid_rise_at", w_fr[5], 6);
    pins0 = '0;
    watch(0, 10);

    // D=1 instance with bit 15 resetting high.
    pins1 = 16'h0000;
    watch(1, 5);
    check("d1_fall_at", w_ff[15], 3);
    check("d1_level",   level1, 16'h0000);
    pins1 = 16'h8000;
    watch(1, 5);
    check("d1_rise_at", w_fr[15], 3);

    // Random stimulus with occasional resets.
    for (int n = 0; n < 10000; n++) begin
      int b;
      if ($urandom_range(0, 3) == 0) begin b = $urandom_range(0, W-1); pins0[b] = ~pins0[b]; end
      if ($urandom_range(0, 3) == 0) begin b = $urandom_range(0, W-1); pins1[b] = ~pins1[b]; end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
